// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI4 read channel between the fetch (I) and data-load (D)
// requesters. Only one read transaction is outstanding at a time.
// Optional feature: define SASANQUA_RR_ARB_EN for round-robin arbitration. Without it,
// arbitration is fixed priority with D over I.
module axi_read_arbiter #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_OFFSET_WIDTH   = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        I_REQ,
  input  logic [C_OFFSET_WIDTH-1:0]   I_ADDR,
  input  logic [7:0]                  I_LEN,
  output logic                        I_GNT,
  output logic                        I_RVALID,
  output logic [C_AXI_DATA_WIDTH-1:0] I_RDATA,
  output logic                        I_RLAST,
  output logic                        I_RERR,
  input  logic                        D_REQ,
  input  logic [C_OFFSET_WIDTH-1:0]   D_ADDR,
  input  logic [7:0]                  D_LEN,
  output logic                        D_GNT,
  output logic                        D_RVALID,
  output logic [C_AXI_DATA_WIDTH-1:0] D_RDATA,
  output logic                        D_RLAST,
  output logic                        D_RERR,
  output logic [C_OFFSET_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                  M_AXI_ARLEN,
  output logic [2:0]                  M_AXI_ARSIZE,
  output logic [1:0]                  M_AXI_ARBURST,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  output logic                        BUSY
);

  localparam int unsigned SizeLog2 = $clog2(C_AXI_DATA_WIDTH / 8);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                    state_q, state_d;
  logic                      owner_d_q, owner_d_d;  // 1: data-load requester owns the burst
  logic [C_OFFSET_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                arlen_q, arlen_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      i_gnt_q, i_gnt_d;
  logic                      d_gnt_q, d_gnt_d;
  logic                      pick_d;
  logic                      beat;
  logic                      beat_err;
  logic                      unused_rresp0;

  // Only the error bit of RRESP matters; EXOKAY is treated like OKAY.
  assign unused_rresp0 = M_AXI_RRESP[0];

`ifdef SASANQUA_RR_ARB_EN
  logic favour_d_q, favour_d_d;

  // Winner select: on a tie the requester not granted last wins.
  always_comb begin
    pick_d = D_REQ;
    if (I_REQ && D_REQ) pick_d = favour_d_q;
  end

  // Pointer moves to the loser whenever a grant is issued.
  always_comb begin
    favour_d_d = favour_d_q;
    if (state_q == StIdle && (I_REQ || D_REQ)) favour_d_d = ~pick_d;
  end

  // Round-robin pointer register; D wins the first tie after reset.
  always_ff @(posedge CLK) begin
    if (!RST) favour_d_q <= 1'b1;
    else      favour_d_q <= favour_d_d;
  end
`else
  // Fixed priority: D always beats I.
  assign pick_d = D_REQ;
`endif

  // Next-state logic: grant in IDLE, hand-shake AR in ADDR, count beats in DATA.
  always_comb begin
    state_d   = state_q;
    owner_d_d = owner_d_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    cnt_d     = cnt_q;
    i_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (I_REQ || D_REQ) begin
          owner_d_d = pick_d;
          araddr_d  = pick_d ? D_ADDR : I_ADDR;
          arlen_d   = pick_d ? D_LEN : I_LEN;
          cnt_d     = 8'd0;
          i_gnt_d   = ~pick_d;
          d_gnt_d   = pick_d;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (M_AXI_ARREADY) state_d = StData;
      end
      StData: begin
        if (M_AXI_RVALID) begin
          cnt_d = cnt_q + 8'd1;
          if (M_AXI_RLAST) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and AR registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= StIdle;
      owner_d_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= 8'd0;
      cnt_q     <= 8'd0;
      i_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      cnt_q     <= cnt_d;
      i_gnt_q   <= i_gnt_d;
      d_gnt_q   <= d_gnt_d;
    end
  end

  // R-channel steering is combinational so beats reach the owner with no added latency.
  assign beat     = (state_q == StData) && M_AXI_RVALID;
  // A premature or late RLAST is reported as an error on the closing beat.
  assign beat_err = M_AXI_RRESP[1] || (M_AXI_RLAST && (cnt_q != arlen_q));

  assign I_GNT    = i_gnt_q;
  assign I_RVALID = beat && !owner_d_q;
  assign I_RDATA  = I_RVALID ? M_AXI_RDATA : '0;
  assign I_RLAST  = I_RVALID && M_AXI_RLAST;
  assign I_RERR   = I_RVALID && beat_err;

  assign D_GNT    = d_gnt_q;
  assign D_RVALID = beat && owner_d_q;
  assign D_RDATA  = D_RVALID ? M_AXI_RDATA : '0;
  assign D_RLAST  = D_RVALID && M_AXI_RLAST;
  assign D_RERR   = D_RVALID && beat_err;

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARSIZE  = 3'(SizeLog2);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = (state_q == StAddr);
  assign M_AXI_RREADY  = (state_q == StData);
  assign BUSY          = (state_q != StIdle);

endmodule
